// File: rtl/lsu_bus_master_if.sv
// Word-wide data-memory bus between the load/store initiator and a memory responder.
interface lsu_bus_master_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// RV32 load/store bus initiator: splits an access into one or two word-aligned
// beats with byte enables and returns little-endian, extended load data.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       func3,
    input  logic [31:0]      address,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             done,
    output logic             err,
    lsu_bus_master_if.master bus
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t           state;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             zext_q;
    logic             we_q;
    logic [31:0]      hi_addr_q;
    logic [3:0]       hi_be_q;
    logic [31:0]      hi_wdata_q;
    logic [31:0]      lo_rdata_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  base;
    logic [7:0]  mask;
    logic [63:0] lanes;
    logic        legal;

    // Accept-time decode: legality, 8-lane byte mask and lane-positioned store data
    always_comb begin
        base = 4'b0000;
        case (func3[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            2'b10:   base = 4'b1111;
            default: base = 4'b0000;
        endcase
        mask  = {4'b0000, base} << address[1:0];
        lanes = {32'h0, wdata} << {address[1:0], 3'b000};
        legal = 1'b0;
        if (mem_read && !mem_write) begin
            legal = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else if (mem_write && !mem_read) begin
            legal = func3 inside {3'b000, 3'b001, 3'b010};
        end
    end

    logic [63:0] rbuf;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // Final-beat load data: the acked word is consumed directly so rdata lands with done
    always_comb begin
        rbuf     = (state == BEAT1) ? {bus.bus_rdata, lo_rdata_q} : {32'h0, bus.bus_rdata};
        shifted  = 32'(rbuf >> {off_q, 3'b000});
        load_val = shifted;
        case (size_q)
            2'b00:   load_val = zext_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = zext_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rdata         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            off_q         <= '0;
            size_q        <= '0;
            zext_q        <= 1'b0;
            we_q          <= 1'b0;
            hi_addr_q     <= '0;
            hi_be_q       <= '0;
            hi_wdata_q    <= '0;
            lo_rdata_q    <= '0;
            cnt_q         <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        off_q     <= address[1:0];
                        size_q    <= func3[1:0];
                        zext_q    <= func3[2];
                        we_q      <= mem_write;
                        cnt_q     <= '0;
                        if (!legal) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state         <= BEAT0;
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_write;
                            bus.bus_addr  <= {address[31:2], 2'b00};
                            bus.bus_be    <= mask[3:0];
                            bus.bus_wdata <= mem_write ? lanes[31:0] : 32'h0;
                            hi_addr_q     <= {address[31:2], 2'b00} + 32'd4;
                            hi_be_q       <= mask[7:4];
                            hi_wdata_q    <= mem_write ? lanes[63:32] : 32'h0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (bus.bus_ack) begin
                        if (state == BEAT0) begin
                            lo_rdata_q <= bus.bus_rdata;
                        end
                        if (state == BEAT0 && hi_be_q != 4'b0000) begin
                            // bus_req stays high straight into the second beat
                            state         <= BEAT1;
                            bus.bus_addr  <= hi_addr_q;
                            bus.bus_be    <= hi_be_q;
                            bus.bus_wdata <= hi_wdata_q;
                            cnt_q         <= '0;
                        end else begin
                            state       <= RESP;
                            bus.bus_req <= 1'b0;
                            done        <= 1'b1;
                            if (!we_q) begin
                                rdata <= load_val;
                            end
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state       <= RESP;
                        bus.bus_req <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: byte-array memory responder plus a byte-level
// reference model of RV32 load/store semantics.
module tb_lsu_bus_master;
    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    lsu_bus_master_if bus_if ();

    lsu_bus_master #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .func3     (func3),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem     [1024];
    logic [7:0]  ref_mem [1024];
    int          d0 = 0;
    int          d1 = 0;
    int          wait_cnt = 0;
    int          beat_idx = 0;
    int          req_hi = 0;
    logic [31:0] log_addr [$];
    logic [3:0]  log_be [$];
    logic [31:0] log_wd [$];
    logic        log_we [$];
    logic [31:0] exp_rdata = 32'h0;

    function automatic int idx(input logic [31:0] a);
        return int'(a & 32'h3FF);
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = mem[idx(a + 32'(i))];
        return v;
    endfunction

    // Responder: acks once the configured per-beat wait has elapsed
    always @(negedge clk) begin
        if (bus_if.bus_req && wait_cnt >= ((beat_idx == 0) ? d0 : d1)) begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = rd_word(bus_if.bus_addr);
        end else begin
            bus_if.bus_ack   = 1'b0;
            bus_if.bus_rdata = $urandom;
        end
    end

    always @(posedge clk) begin
        if (bus_if.bus_req) begin
            req_hi++;
            if (bus_if.bus_ack) begin
                log_addr.push_back(bus_if.bus_addr);
                log_be.push_back(bus_if.bus_be);
                log_wd.push_back(bus_if.bus_wdata);
                log_we.push_back(bus_if.bus_we);
                if (bus_if.bus_we) begin
                    for (int i = 0; i < 4; i++)
                        if (bus_if.bus_be[i]) mem[idx(bus_if.bus_addr + 32'(i))] = bus_if.bus_wdata[8*i +: 8];
                end
                beat_idx++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            beat_idx = 0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[idx(a + 32'(i))];
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            mem[idx(a + 32'(i))]     = v[8*i +: 8];
            ref_mem[idx(a + 32'(i))] = v[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] beat_addr(input int i);
        return (log_addr.size() > i) ? log_addr[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic [3:0] beat_be(input int i);
        return (log_be.size() > i) ? log_be[i] : 4'hx;
    endfunction
    function automatic logic [31:0] beat_wd(input int i);
        return (log_wd.size() > i) ? log_wd[i] : 32'hxxxxxxxx;
    endfunction

    // One access through the DUT, checked against the reference model; dd1 < TO whenever dd0 < TO
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int dd0, input int dd1, output int lat);
        int          n;
        int          beats;
        int          exp_lat;
        int          exp_logged;
        logic        legal;
        logic        tmo;
        logic        got_err;
        logic [31:0] wbase;
        n     = nbytes(f3);
        legal = (rd && !wr && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                (wr && !rd && f3 inside {3'd0, 3'd1, 3'd2});
        beats = (int'(a[1:0]) + n > 4) ? 2 : 1;
        tmo   = legal && dd0 >= int'(TO);
        wbase = {a[31:2], 2'b00};

        @(negedge clk);
        d0 = dd0;
        d1 = dd1;
        req_hi = 0;
        log_addr.delete();
        log_be.delete();
        log_wd.delete();
        log_we.delete();
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        func3     = f3;
        address   = a;
        wdata     = wd;
        chk("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        address   = $urandom;
        wdata     = $urandom;
        lat = 1;
        while (!done) begin
            chk("ready_busy", 32'(req_ready), 32'd0);
            if (lat >= 200) begin
                checks++;
                failures++;
                $error("FAIL done_wait observed=no_done expected=done_within_200");
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        got_err = err;
        chk("ready_resp", 32'(req_ready), 32'd0);

        if (!legal) begin
            exp_lat = 1;
            exp_logged = 0;
        end else if (tmo) begin
            exp_lat = int'(TO) + 1;
            exp_logged = 0;
        end else begin
            exp_lat = 1 + (dd0 + 1) + ((beats == 2) ? dd1 + 1 : 0);
            exp_logged = beats;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(got_err), 32'(!legal || tmo));
        chk("beats", 32'(log_addr.size()), 32'(exp_logged));
        if (!legal) chk("no_req_illegal", 32'(req_hi), 32'd0);
        if (exp_logged >= 1) begin
            chk("beat0_addr", beat_addr(0), wbase);
            chk("beat0_we", 32'(log_we[0]), 32'(wr));
        end
        if (exp_logged == 2) chk("beat1_addr", beat_addr(1), wbase + 32'd4);

        if (legal && !tmo && wr)
            for (int i = 0; i < n; i++) ref_mem[idx(a + 32'(i))] = wd[8*i +: 8];
        if (legal && !tmo && rd) exp_rdata = model_load(a, f3);

        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("err_pulse", 32'(err), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("rdata", rdata, exp_rdata);
        if (legal && wr)
            for (int i = 0; i < 8; i++)
                chk("mem_byte", 32'(mem[idx(wbase + 32'(i))]), 32'(ref_mem[idx(wbase + 32'(i))]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        func3     = 3'd0;
        address   = 32'h0;
        wdata     = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_if.bus_be), 32'h0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // sw, single aligned beat
        txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_be", 32'(beat_be(0)), 32'hF);
        chk("sw_wd", beat_wd(0), 32'hDEADBEEF);

        // lb / lbu from the top lane
        set_word(32'h100, 32'h80123456);
        txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, lat);
        chk("lb_be", 32'(beat_be(0)), 32'h8);
        chk("lb_val", rdata, 32'hFFFFFF80);
        txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 0, lat);
        chk("lbu_val", rdata, 32'h00000080);

        // misaligned lw split across two words
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, lat);
        chk("lw2_lat", 32'(lat), 32'd3);
        chk("lw2_be0", 32'(beat_be(0)), 32'hC);
        chk("lw2_be1", 32'(beat_be(1)), 32'h3);
        chk("lw2_val", rdata, 32'h66554433);

        // misaligned sh
        txn(1'b0, 1'b1, 3'b001, 32'h103, 32'h0000ABCD, 0, 2, lat);
        chk("sh_be0", 32'(beat_be(0)), 32'h8);
        chk("sh_wd0", beat_wd(0), 32'hCD000000);
        chk("sh_be1", 32'(beat_be(1)), 32'h1);
        chk("sh_wd1", beat_wd(1), 32'h000000AB);

        // timeout, then ack exactly on the last allowed cycle
        txn(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 99, 99, lat);
        chk("tmo_req_cycles", 32'(req_hi), 32'(TO));
        chk("tmo_rdata_held", rdata, 32'h66554433);
        txn(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, int'(TO) - 1, 0, lat);
        chk("late_ack_lat", 32'(lat), 32'(TO + 1));
        chk("late_ack_err", 32'(err), 32'd0);

        // illegal encodings and type combinations
        txn(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, lat);
        txn(1'b0, 1'b1, 3'b100, 32'h100, 32'h1234, 0, 0, lat);
        txn(1'b1, 1'b1, 3'b010, 32'h100, 32'h1234, 0, 0, lat);
        txn(1'b0, 1'b0, 3'b010, 32'h100, 32'h1234, 0, 0, lat);

        // address wrap at the top of the 32-bit space
        txn(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 0, lat);
        chk("wrap_addr1", beat_addr(1), 32'h0);

        for (int k = 0; k < 80; k++) begin
            int          kind;
            int          op;
            int          x0;
            int          x1;
            logic        rd;
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 11);
            op   = $urandom_range(0, 9);
            x0   = $urandom_range(0, 3);
            x1   = $urandom_range(0, 3);
            if (kind == 0) begin
                x0 = int'(TO) + 4;
                x1 = int'(TO) + 4;
            end else if (kind == 1) begin
                x0 = int'(TO) - 1;
            end
            rd = 1'b1;
            wr = 1'b0;
            f3 = 3'd0;
            if (op == 0) begin
                case ($urandom_range(0, 3))
                    0: begin rd = 1'b1; wr = 1'b0; f3 = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'(6 + $urandom_range(0, 1)); end
                    1: begin rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(3, 7)); end
                    2: begin rd = 1'b1; wr = 1'b1; f3 = 3'($urandom_range(0, 2)); end
                    default: begin rd = 1'b0; wr = 1'b0; f3 = 3'($urandom_range(0, 2)); end
                endcase
            end else if (op < 6) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                rd = 1'b0;
                wr = 1'b1;
                f3 = 3'($urandom_range(0, 2));
            end
            a = $urandom;
            if (k % 5 == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            txn(rd, wr, f3, a, $urandom, x0, x1, lat);
        end

        // asynchronous reset while the second beat of a misaligned lw is pending
        set_word(32'h300, 32'h11223344);
        set_word(32'h304, 32'h55667788);
        @(negedge clk);
        d0 = 0;
        d1 = 99;
        req_valid = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        func3     = 3'b010;
        address   = 32'h302;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("beat1_pending", 32'(bus_if.bus_req), 32'd1);
        chk("beat1_addr_pending", bus_if.bus_addr, 32'h304);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        exp_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done), 32'd0);
        txn(1'b1, 1'b0, 3'b010, 32'h302, 32'h0, 0, 0, lat);
        chk("post_rst_lw", rdata, 32'h77881122);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
